muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the EX stage.
//  Replaces single-cycle combinational MULT/DIV with a shift-add multiplier and a restoring divider.
//  EX issues an op with a Start pulse; the unit iterates, then updates HI/LO and pulses Done.
//  A pending MFHI/MFLO is held off through Stall until HI/LO are valid.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width; iteration count
// PORTS
//  CLK    in   1      clock; all state updates on rising edge
//  RST    in   1      synchronous active-high reset
//  Start  in   1      op request; sampled only in IDLE
//  Op     in   3      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
//  Rdata1 in   WIDTH  rs: multiplicand/dividend
//  Rdata2 in   WIDTH  rt: multiplier/divisor/MTHI-MTLO source
//  MfReq  in   1      EX holds MFHI/MFLO this cycle
//  Busy   out  1      state != IDLE
//  Done   out  1      one-cycle pulse; HI/LO hold the new result
//  Stall  out  1      MfReq & Busy, combinational
//  Hi     out  WIDTH  HI register
//  Lo     out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE, Hi=Lo=0, Busy=Done=0, iteration counter=0, internal regs=0.
//  FSM: IDLE -> CALC when Start & Op is mul/div. CALC lasts WIDTH cycles (cnt 0..WIDTH-1).
//   CALC -> SIGN at cnt==WIDTH-1. SIGN -> IDLE always.
//  Timing: Start sampled at edge k. CALC occupies cycles k+1..k+32; SIGN is cycle k+33.
//   Hi/Lo are written at the end of SIGN. Done is high in cycle k+34 only.
//   Busy is high from cycle k+1 through k+33.
//  Start is accepted in the Done cycle; back-to-back ops therefore lose no cycle.
//   Start while Busy is ignored; EX must not issue it.
//  MTHI/MTLO: when Start is sampled in IDLE, write Rdata2 to Hi or Lo at that edge.
//   Not Busy; no Done; the other register is unchanged.
//  Signed ops (MULT, DIV):
//   Capture |Rdata1| and |Rdata2| at Start; latch neg_q = sign1^sign2 and neg_r = sign1.
//   In SIGN: negate the product if neg_q (64-bit two's complement). For DIV, negate Lo if neg_q and Hi if neg_r.
//   0x80000000 magnitude is handled as an unsigned 32-bit value; no overflow trap.
//  Multiply:
//   64-bit {acc,mplr}. Each CALC cycle: if mplr[0], add mcand to acc with a 33-bit carry; then shift right 1.
//   Final {Hi,Lo} = 64-bit product.
//  Divide (restoring):
//   Each cycle, shift {rem,quo} left 1. Trial = rem - divisor (33-bit).
//   If non-negative: rem=trial, quo[0]=1.
//   Final Lo=quotient, Hi=remainder; sign of remainder follows dividend.
//  Divide by zero: no trap. Still takes full latency. Result Lo=32'hFFFFFFFF, Hi=dividend.
//   Both values are raw, before sign fix-up; the sign fix-up is skipped.
//  Reset mid-operation: aborts at that edge. Hi/Lo=0; no Done pulse.
//  Stall depends only on Busy. In the Done cycle Stall=0 and MFHI/MFLO read the new values.
//  Op values outside the encoding: treated as no-op; state stays IDLE.
// STRUCTURE
//  OP_* localparams (3-bit) belong in common_param.vh, shared with the EX decoder.
//  The EX decoder maps Funct to OP_*.
//  FSM state encoding stays local to this module (IDLE=0, CALC=1, SIGN=2).
//  One sub-module: md_sign_fix, combinational two's-complement conditioning of a 64-bit result.
//   Reused at operand capture (32-bit lanes) and in SIGN.
//  Single shared 33-bit adder/subtractor, muxed by the op latched at Start.
// TESTING
//  Test 1: MULT.
//   Stimulus: Rdata1=FFFFFFFD (-3), Rdata2=5.
//   Expect: Busy for 33 cycles, Done at k+34, Hi=FFFFFFFF, Lo=FFFFFFF1.
//  Test 2: MULTU.
//   Stimulus: FFFFFFFF*FFFFFFFF.
//   Expect: Hi=FFFFFFFE, Lo=00000001.
//  Test 3: DIV.
//   Stimulus: -7/2.
//   Expect: Lo=FFFFFFFD, Hi=FFFFFFFF. Then DIVU 7/2 issued in the Done cycle -> Lo=3, Hi=1 at +34.
//  Test 4: DIVU by zero.
//   Stimulus: 10/0.
//   Expect: Lo=FFFFFFFF, Hi=0000000A, Done at k+34.
//  Test 5: Stall and write rules.
//   Stimulus: MfReq held during an op; then MTHI with Rdata2=1234 while Busy; then MTLO with Rdata2=55 in IDLE.
//   Expect: Stall=1 exactly while Busy. MTHI while Busy is ignored (Hi unchanged). MTLO sets Lo=55 next cycle; Hi unchanged.
//  Test 6: Reset mid-operation.
//   Stimulus: RST high in cycle k+10 of a MULT.
//   Expect: next cycle Busy=0, Hi=Lo=0, no Done. A new Start then completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encoding and opcode classification helpers for the HI/LO
// multiply/divide sequencer and the EX decoder.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  function automatic logic op_is_mul(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU: op_is_mul = 1'b1;
      default:           op_is_mul = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    case (op)
      OP_DIV, OP_DIVU: op_is_div = 1'b1;
      default:         op_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    case (op)
      OP_MULT, OP_DIV: op_is_signed = 1'b1;
      default:         op_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Two's-complement conditioning of a double-width value: either the whole
// value (wide) or its two halves independently.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] val,
  input  logic               wide,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [2*WIDTH-1:0] res
);

  // In wide mode neg_lo selects negation of the full value.
  always_comb begin
    res = val;
    if (wide) begin
      res = neg_lo ? -val : val;
    end else begin
      res[2*WIDTH-1:WIDTH] = neg_hi ? -val[2*WIDTH-1:WIDTH] : val[2*WIDTH-1:WIDTH];
      res[WIDTH-1:0]       = neg_lo ? -val[WIDTH-1:0]       : val[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider owning the HI/LO pair.
// One 33-bit adder is shared by both algorithms.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic             MfReq,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;   // product high half / remainder
  logic [WIDTH-1:0] lo_r;    // multiplier / quotient
  logic [WIDTH-1:0] opnd_r;  // multiplicand / divisor
  logic [CW-1:0]    cnt_r;
  logic [2:0]       op_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;

  logic [2*WIDTH-1:0] cap_s;
  logic [2*WIDTH-1:0] fix_s;
  logic               start_signed_s;
  logic               mul_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     add_a_s;
  logic [WIDTH:0]     add_b_s;
  logic               cin_s;
  logic [WIDTH:0]     sum_s;

  assign start_signed_s = op_is_signed(Op);
  assign mul_s          = op_is_mul(op_r);
  assign shifted_s      = {acc_r, lo_r[WIDTH-1]};

  md_sign_fix #(.WIDTH(WIDTH)) u_cap_fix (
    .val    ({Rdata1, Rdata2}),
    .wide   (1'b0),
    .neg_hi (start_signed_s & Rdata1[WIDTH-1]),
    .neg_lo (start_signed_s & Rdata2[WIDTH-1]),
    .res    (cap_s)
  );

  // Divide-by-zero results are delivered raw, without sign fix-up.
  md_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
    .val    ({acc_r, lo_r}),
    .wide   (mul_s),
    .neg_hi (neg_r_r & ~div0_r),
    .neg_lo (neg_q_r & ~div0_r),
    .res    (fix_s)
  );

  // Shared adder: accumulate for multiply, trial subtract for divide.
  always_comb begin
    add_a_s = {1'b0, acc_r};
    add_b_s = {(WIDTH+1){1'b0}};
    cin_s   = 1'b0;
    if (mul_s) begin
      add_a_s = {1'b0, acc_r};
      add_b_s = lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}};
      cin_s   = 1'b0;
    end else begin
      add_a_s = shifted_s;
      add_b_s = ~{1'b0, opnd_r};
      cin_s   = 1'b1;
    end
    sum_s = add_a_s + add_b_s + {{WIDTH{1'b0}}, cin_s};
  end

  assign Busy  = (state_r != IDLE);
  assign Stall = MfReq & Busy;

  // Sequencer, iteration datapath and HI/LO registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      op_r    <= 3'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
      Hi      <= {WIDTH{1'b0}};
      Lo      <= {WIDTH{1'b0}};
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_r <= CALC;
                op_r    <= Op;
                cnt_r   <= {CW{1'b0}};
                acc_r   <= {WIDTH{1'b0}};
                lo_r    <= op_is_mul(Op) ? cap_s[WIDTH-1:0] : cap_s[2*WIDTH-1:WIDTH];
                opnd_r  <= op_is_mul(Op) ? cap_s[2*WIDTH-1:WIDTH] : cap_s[WIDTH-1:0];
                neg_q_r <= start_signed_s & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                neg_r_r <= start_signed_s & Rdata1[WIDTH-1];
                div0_r  <= op_is_div(Op) & (Rdata2 == {WIDTH{1'b0}});
              end
              OP_MTHI: Hi <= Rdata2;
              OP_MTLO: Lo <= Rdata2;
              default: state_r <= IDLE;
            endcase
          end
        end
        CALC: begin
          if (mul_s) begin
            acc_r <= sum_s[WIDTH:1];
            lo_r  <= {sum_s[0], lo_r[WIDTH-1:1]};
          end else if (!sum_s[WIDTH]) begin
            acc_r <= sum_s[WIDTH-1:0];
            lo_r  <= {lo_r[WIDTH-2:0], 1'b1};
          end else begin
            acc_r <= shifted_s[WIDTH-1:0];
            lo_r  <= {lo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_r <= SIGN;
          end else begin
            state_r <= CALC;
          end
        end
        SIGN: begin
          Hi      <= fix_s[2*WIDTH-1:WIDTH];
          Lo      <= fix_s[WIDTH-1:0];
          Done    <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized mul/div
// traffic checked against plain-arithmetic reference results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int DONE_LAT = 33;  // edges from the Start-sampling edge to Done
  localparam int BUSY_LEN = 33;

  logic        CLK = 1'b0;
  logic        RST, Start, MfReq;
  logic [2:0]  Op;
  logic [31:0] Rdata1, Rdata2;
  logic        Busy, Done, Stall;
  logic [31:0] Hi, Lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .MfReq(MfReq), .Busy(Busy), .Done(Done), .Stall(Stall), .Hi(Hi), .Lo(Lo)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] exp;
    int          start;
  } sb_t;

  sb_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          busy_run = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hi_m, lo_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: Stall rule every cycle; scoreboard pop on each Done pulse.
  always @(negedge CLK) begin
    sb_t e;
    if (mon_en) begin
      check("stall", {63'd0, Stall}, {63'd0, MfReq & Busy});
      if (Done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done at cycle %0d (no op outstanding)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("hi", {32'd0, Hi}, {32'd0, e.exp[63:32]});
          check("lo", {32'd0, Lo}, {32'd0, e.exp[31:0]});
          check("done_latency", 64'(cyc - e.start), 64'(DONE_LAT));
          check("busy_len", 64'(busy_run), 64'(BUSY_LEN));
        end
        busy_run = 0;
      end else if (Busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Waits for IDLE (entered at a negedge), issues one op, returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, output int st);
    int guard = 0;
    while (Busy && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL idle_wait busy=%b after %0d cycles", Busy, guard);
    end
    Start  = 1'b1;
    Op     = op;
    Rdata1 = a;
    Rdata2 = b;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    st = cyc;
    if (op_is_mul(op) || op_is_div(op)) begin
      exp_q.push_back('{exp, cyc});
      hi_m = exp[63:32];
      lo_m = exp[31:0];
    end else if (op == OP_MTHI) begin
      hi_m = b;
    end else if (op == OP_MTLO) begin
      lo_m = b;
    end
    @(negedge CLK);
  endtask

  initial begin
    int          st, st2, guard;
    logic [31:0] hi_before, a, b;
    logic [2:0]  op;
    logic [31:0] corners[6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007};

    RST = 1'b1; Start = 1'b0; MfReq = 1'b0; Op = 3'd0; Rdata1 = 32'd0; Rdata2 = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    check("reset_hi", {32'd0, Hi}, 64'd0);
    check("reset_lo", {32'd0, Lo}, 64'd0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    // Directed results with hand-derived values
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, st);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, st);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, st);
    issue(OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, st2);
    check("back_to_back_start", 64'(st2 - st), 64'(DONE_LAT + 1));
    issue(OP_DIVU,  32'd10,        32'd0,         64'h0000_000A_FFFF_FFFF, st);

    // Stall while busy, MTHI ignored while busy, MTLO in IDLE
    hi_before = hi_m;
    MfReq = 1'b1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, st);
    check("busy_hi_before", {32'd0, Hi}, {32'd0, hi_before});
    Start = 1'b1; Op = OP_MTHI; Rdata2 = 32'h1234;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    @(negedge CLK);
    check("mthi_while_busy", {32'd0, Hi}, {32'd0, hi_before});
    check("stall_direct", {63'd0, Stall}, 64'd1);
    issue(OP_MTLO, 32'd0, 32'h55, 64'd0, st);
    MfReq = 1'b0;
    check("mtlo_lo", {32'd0, Lo}, 64'h55);
    check("mtlo_hi", {32'd0, Hi}, 64'h1);
    check("mtlo_busy", {63'd0, Busy}, 64'd0);
    issue(OP_MTHI, 32'd0, 32'hCAFE_0001, 64'd0, st);
    check("mthi_hi", {32'd0, Hi}, 64'hCAFE_0001);
    check("mthi_lo", {32'd0, Lo}, 64'h55);

    // Unencoded op is a no-op
    issue(3'd6, 32'd1, 32'd2, 64'd0, st);
    check("noop_busy", {63'd0, Busy}, 64'd0);
    check("noop_hi", {32'd0, Hi}, {32'd0, hi_m});
    check("noop_lo", {32'd0, Lo}, {32'd0, lo_m});

    // Reset mid-operation
    issue(OP_MULT, 32'd7, 32'd9, 64'd63, st);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge CLK);
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check("rst_mid_done", {63'd0, Done}, 64'd0);
    check("rst_mid_hi", {32'd0, Hi}, 64'd0);
    check("rst_mid_lo", {32'd0, Lo}, 64'd0);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, st);

    // Randomized mul/div traffic with occasional idle gaps
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      if (op == OP_DIV && b == 32'd0) b = 32'd3;
      issue(op, a, b, model(op, a, b), st);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
